// File: rtl/selector_nway_reg_if.sv
// selector_nway_reg_if: bundles the multi-channel input handshake, the mode/select
// controls and the registered output handshake of selector_nway_reg.
//   master : producer/consumer side (drives in_data/in_valid/mode/sel/out_ready)
//   slave  : selector side (drives in_ready/out_data/out_valid/out_chan)
interface selector_nway_reg_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
);
    logic [WIDTH*CHANNELS-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_chan;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/selector_nway_reg.sv
// selector_nway_reg: registered N-way selector. Grants one requesting channel per
// cycle, either the channel named by sel (mode=0) or round-robin from ptr (mode=1),
// and captures its word into a one-entry output register with valid/ready.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave modport of selector_nway_reg_if (inputs, controls, output reg)
module selector_nway_reg #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                 clk,
    input  logic                 rst,
    selector_nway_reg_if.slave   bus
);

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    out_chan_q, out_chan_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;

    logic                grant_vld;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic                load_en;
    logic                xfer_in;
    logic                xfer_out;
    logic [CHANNELS-1:0] in_ready_c;
    int                  rr_idx;

    // Grant arbitration: direct index or first requester at/after ptr (wrapping).
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        if (!bus.mode) begin
            // Comparing against each legal index means sel >= CHANNELS never matches.
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                rr_idx = int'(ptr_q) + k;
                if (rr_idx >= int'(CHANNELS)) begin
                    rr_idx = rr_idx - int'(CHANNELS);
                end
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    if (!grant_vld && i == rr_idx && bus.in_valid[i]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
        end
    end

    // Mux the granted channel's word.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load_en  = !out_valid_q || bus.out_ready;
    assign xfer_in  = grant_vld && load_en && !rst;
    assign xfer_out = out_valid_q && bus.out_ready;

    // One-hot accept towards the granted channel only.
    always_comb begin
        in_ready_c = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (xfer_in && grant_idx == SEL_W'(i)) begin
                in_ready_c[i] = 1'b1;
            end
        end
    end

    // Next state of output register and round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (xfer_in) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (bus.mode) begin
                if (grant_idx == SEL_W'(CHANNELS - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_idx + SEL_W'(1);
                end
            end
        end else if (xfer_out) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;

endmodule
